// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, parity-type and legal prescale constants
// for the UART receive path, plus a 2-of-3 majority helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int unsigned PRESC_8  = 8;
   localparam int unsigned PRESC_16 = 16;
   localparam int unsigned PRESC_32 = 32;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and mid-bit sample logic.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority over the three samples
// centred on PRESCALE/2, decided one cycle later at PRESCALE/2+1.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               rx_s,
   input  logic               run,
   input  logic [PRESC_W-1:0] presc,
   output logic               sampled_bit,
   output logic               sample_stb,
   output logic               bit_done
);

   logic [PRESC_W-1:0] edge_cnt;
   logic [PRESC_W-1:0] half;

   // half-bit point and end-of-bit wrap detection
   always_comb begin
      half     = presc >> 1;
      bit_done = run && (edge_cnt == presc - PRESC_W'(1));
   end

   // edge counter: 0..presc-1 per bit, held at 0 while the FSM is idle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         edge_cnt <= '0;
      else if (!run || bit_done)
         edge_cnt <= '0;
      else
         edge_cnt <= edge_cnt + PRESC_W'(1);
   end

`ifdef UART_RX_MAJORITY_EN
   logic smp_a;
   logic smp_b;

   // capture the two early samples; the third is the live rx_s at half+1
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         smp_a <= 1'b1;
         smp_b <= 1'b1;
      end else if (run) begin
         if (edge_cnt == half - PRESC_W'(1))
            smp_a <= rx_s;
         if (edge_cnt == half)
            smp_b <= rx_s;
      end
   end

   // majority decision presented one cycle after the centre sample
   always_comb begin
      sample_stb  = run && (edge_cnt == half + PRESC_W'(1));
      sampled_bit = maj3(smp_a, smp_b, rx_s);
   end
`else
   // single sample at the bit centre
   always_comb begin
      sample_stb  = run && (edge_cnt == half);
      sampled_bit = rx_s;
   end
`endif

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver - synchronizer, frame FSM, LSB-first shift
// register, parity/stop checks and one-cycle result strobes.
// Build option UART_RX_MAJORITY_EN (in uart_rx_sampler) selects majority sampling.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESC_W-1:0]    PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

   rx_state_e             state;
   rx_state_e             state_nxt;
   logic                  rx_m;
   logic                  rx_s;
   logic [PRESC_W-1:0]    presc_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [BCW-1:0]        bit_cnt;
   logic                  armed;
   logic                  par_bad;
   logic                  run;
   logic                  start_go;
   logic                  frame_end;
   logic                  sampled_bit;
   logic                  sample_stb;
   logic                  bit_done;

   // two-flop synchronizer, idle-high reset value
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= RX_IN;
         rx_s <= rx_m;
      end
   end

   uart_rx_sampler #(
      .PRESC_W (PRESC_W)
   ) u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .rx_s        (rx_s),
      .run         (run),
      .presc       (presc_q),
      .sampled_bit (sampled_bit),
      .sample_stb  (sample_stb),
      .bit_done    (bit_done)
   );

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic; STOP exits at the sample point so a back-to-back start is caught
   always_comb begin
      state_nxt = state;
      start_go  = 1'b0;
      frame_end = 1'b0;
      run       = (state != IDLE);
      case (state)
         IDLE: begin
            if (armed && !rx_s) begin
               state_nxt = START;
               start_go  = 1'b1;
            end
         end
         START: begin
            if (sample_stb && sampled_bit)
               state_nxt = IDLE;
            else if (bit_done)
               state_nxt = DATA;
         end
         DATA: begin
            if (bit_done && (bit_cnt == BCW'(DATA_WIDTH - 1)))
               state_nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_done)
               state_nxt = STOP;
         end
         STOP: begin
            if (sample_stb) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // frame datapath: config latch, rearm flag, bit counter, shift register, parity check
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         armed     <= 1'b0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         par_bad   <= 1'b0;
      end else begin
         if (state == IDLE && rx_s)
            armed <= 1'b1;
         if (start_go) begin
            presc_q   <= PRESCALE;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            par_bad   <= 1'b0;
         end
         if (state == DATA && sample_stb)
            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
         if (state == DATA && bit_done)
            bit_cnt <= bit_cnt + BCW'(1);
         if (state == PARITY && sample_stb)
            par_bad <= sampled_bit != ((par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q);
      end
   end

   // result strobes and held output word
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         if (frame_end) begin
            if (sampled_bit && !par_bad) begin
               P_DATA     <= shift_q;
               data_valid <= 1'b1;
            end else begin
               stp_err <= ~sampled_bit;
               par_err <= par_bad;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core. The driver serialises
// frames and queues the outcome predicted from the frame contents; a monitor
// pops and compares whenever a result strobe appears.
module tb_uart_rx_core;
   import uart_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 6;

   typedef struct packed {
      logic          dv;
      logic          pe;
      logic          se;
      logic [DW-1:0] data;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] PRESCALE = PW'(PRESC_8);
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          data_valid;
   logic          par_err;
   logic          stp_err;

   exp_t          exp_q[$];
   logic [DW-1:0] last_good = '0;
   int            tests = 0;
   int            fails = 0;

   always #5 CLK = ~CLK;

   uart_rx_core #(
      .DATA_WIDTH (DW),
      .PRESC_W    (PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PRESCALE   (PRESCALE),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // reference: outcome of a frame from its contents alone
   task automatic expect_frame(input logic [DW-1:0] d, input logic par_en, input logic par_typ,
                               input logic pbit, input logic stopbit);
      exp_t e;
      logic want_p;
      logic pmis;
      want_p = (($countones(d) % 2) == 1) ^ par_typ;
      pmis   = par_en && (pbit != want_p);
      if (!pmis && stopbit) begin
         e = '{dv: 1'b1, pe: 1'b0, se: 1'b0, data: d};
         last_good = d;
      end else begin
         e = '{dv: 1'b0, pe: pmis, se: ~stopbit, data: last_good};
      end
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input int unsigned p, input logic par_en, input logic par_typ,
                             input logic [DW-1:0] d, input logic pbit, input logic stopbit,
                             input int unsigned idle_bits, input logic disturb);
      PRESCALE = PW'(p);
      PAR_EN   = par_en;
      PAR_TYP  = par_typ;
      expect_frame(d, par_en, par_typ, pbit, stopbit);
      RX_IN = 1'b0;
      tick(p);
      if (disturb) begin
         PRESCALE = PW'((p == PRESC_8) ? PRESC_32 : PRESC_8);
         PAR_EN   = ~par_en;
         PAR_TYP  = ~par_typ;
      end
      for (int i = 0; i < int'(DW); i++) begin
         RX_IN = d[i];
         tick(p);
      end
      if (par_en) begin
         RX_IN = pbit;
         tick(p);
      end
      RX_IN = stopbit;
      tick(p);
      RX_IN = 1'b1;
      tick(p * idle_bits);
   endtask

   function automatic logic good_parity(input logic [DW-1:0] d, input logic typ);
      return (($countones(d) % 2) == 1) ^ typ;
   endfunction

   // monitor: every strobe cycle must match the head of the scoreboard
   always @(negedge CLK) begin
      exp_t e;
      if (RST && (data_valid || par_err || stp_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {29'd0, data_valid, par_err, stp_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("strobes", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.dv, e.pe, e.se});
            check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
         end
      end
   end

   initial begin
      logic [DW-1:0] d55;
      logic [DW-1:0] d3;
      logic [DW-1:0] rd;
      logic          rpe;
      logic          rtyp;
      logic          rstop;
      int unsigned   rp;

      // reset state
      tick(4);
      check("reset_p_data", {24'd0, P_DATA}, 32'd0);
      check("reset_strobes", {29'd0, data_valid, par_err, stp_err}, 32'd0);
      RST = 1'b1;
      tick(10);

      // directed frames
      send_frame(PRESC_8, 1'b0, PAR_EVEN, 8'hA5, 1'b0, 1'b1, 2, 1'b0);
      send_frame(PRESC_16, 1'b1, PAR_EVEN, 8'h3C, 1'b0, 1'b1, 2, 1'b0);
      send_frame(PRESC_16, 1'b1, PAR_EVEN, 8'h3C, 1'b1, 1'b1, 2, 1'b0);
      send_frame(PRESC_32, 1'b0, PAR_EVEN, 8'h81, 1'b0, 1'b0, 2, 1'b0);
      send_frame(PRESC_32, 1'b0, PAR_EVEN, 8'h7E, 1'b0, 1'b1, 2, 1'b0);

      // short low glitch: no strobe expected
      PRESCALE = PW'(PRESC_8);
      PAR_EN   = 1'b0;
      RX_IN = 1'b0;
      tick(3);
      RX_IN = 1'b1;
      tick(40);

      // line break for 12 frame times: a single stop error
      expect_frame('0, 1'b0, PAR_EVEN, 1'b0, 1'b0);
      RX_IN = 1'b0;
      tick(12 * 10 * PRESC_8);
      RX_IN = 1'b1;
      tick(3 * 10 * PRESC_8);

      // mid-bit spike on data bit 3 of 0x55
`ifdef UART_RX_MAJORITY_EN
      expect_frame(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1);
`else
      expect_frame(8'h5D, 1'b0, PAR_EVEN, 1'b0, 1'b1);
`endif
      d55 = 8'h55;
      RX_IN = 1'b0;
      tick(PRESC_8);
      for (int i = 0; i < int'(DW); i++) begin
         RX_IN = d55[i];
         if (i == 3) begin
            tick(PRESC_8 / 2 + 1);
            RX_IN = 1'b1;
            tick(1);
            RX_IN = 1'b0;
            tick(PRESC_8 / 2 - 2);
         end else begin
            tick(PRESC_8);
         end
      end
      RX_IN = 1'b1;
      tick(2 * PRESC_8);

      // back-to-back frames with no idle gap
      send_frame(PRESC_8, 1'b0, PAR_EVEN, 8'h11, 1'b0, 1'b1, 0, 1'b0);
      send_frame(PRESC_8, 1'b0, PAR_EVEN, 8'h22, 1'b0, 1'b1, 0, 1'b0);

      // reset in the middle of a third frame
      d3 = 8'h33;
      RX_IN = 1'b0;
      tick(PRESC_8);
      for (int i = 0; i < 3; i++) begin
         RX_IN = d3[i];
         tick(PRESC_8);
      end
      RST = 1'b0;
      tick(2);
      check("midframe_rst_p_data", {24'd0, P_DATA}, 32'd0);
      check("midframe_rst_strobes", {29'd0, data_valid, par_err, stp_err}, 32'd0);
      last_good = '0;
      RX_IN = 1'b1;
      tick(2);
      RST = 1'b1;
      tick(20);
      send_frame(PRESC_8, 1'b1, PAR_ODD, 8'h96, good_parity(8'h96, PAR_ODD), 1'b1, 1, 1'b0);

      // randomized frames, config inputs sometimes disturbed mid-frame
      for (int n = 0; n < 24; n++) begin
         case ($urandom % 3)
            0:       rp = PRESC_8;
            1:       rp = PRESC_16;
            default: rp = PRESC_32;
         endcase
         rd    = DW'($urandom);
         rpe   = 1'($urandom % 2);
         rtyp  = 1'($urandom % 2);
         rstop = ($urandom % 6) != 0;
         send_frame(rp, rpe, rtyp, rd, good_parity(rd, rtyp) ^ (($urandom % 4) == 0), rstop,
                    rstop ? ($urandom % 3) : (1 + $urandom % 2), 1'($urandom % 2));
      end

      // bounded drain of outstanding expectations
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
         tick(1);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      tick(100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
